// File: rtl/chord_voice_allocator.sv
// Chord voice allocator: assigns song-reader notes to note_player voices and paces time-advance entries.
// Optional build macro VOICE_STEAL_EN: overwrite the least-remaining busy voice instead of dropping.
module chord_voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  play_enable_i,
  input  logic                  beat_i,
  input  logic                  load_new_note_i,
  input  logic                  advance_i,
  input  logic [NOTE_W-1:0]     note_to_load_i,
  input  logic [DUR_W-1:0]      duration_i,
  output logic [NUM_VOICES-1:0] voice_load_o,
  output logic [NOTE_W-1:0]     voice_note_o,
  output logic [DUR_W-1:0]      voice_duration_o,
  output logic [NUM_VOICES-1:0] voice_active_o,
  output logic                  note_done_o,
  output logic                  steal_o,
  output logic                  drop_o
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [DUR_W-1:0] DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

  typedef enum logic {ACCEPT = 1'b0, WAIT = 1'b1} state_e;

  state_e                  state_q;
  logic [DUR_W-1:0]        adv_q;
  logic [DUR_W-1:0]        cnt_q [NUM_VOICES];
  logic [DUR_W-1:0]        cnt_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   active_d;
  logic [NUM_VOICES-1:0]   active_q;
  logic [NUM_VOICES-1:0]   load_d;
  logic [NUM_VOICES-1:0]   load_q;
  logic [NOTE_W-1:0]       note_q;
  logic [DUR_W-1:0]        dur_q;
  logic                    done_q;
  logic                    steal_q;
  logic                    drop_q;

  logic                    free_found_s;
  logic [IDX_W-1:0]        free_idx_s;
  logic [IDX_W-1:0]        tgt_s;
  logic                    note_req_s;
  logic                    do_load_s;
  logic                    steal_d;
  logic                    drop_d;
`ifdef VOICE_STEAL_EN
  logic [IDX_W-1:0]        min_idx_s;
  logic [DUR_W-1:0]        min_val_s;
`endif

  // Voice selection and next counter values; allocation sees pre-beat counts.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = {IDX_W{1'b0}};
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (cnt_q[i] == DUR_ZERO) begin
        free_found_s = 1'b1;
        free_idx_s   = i[IDX_W-1:0];
      end else begin
        free_found_s = free_found_s;
      end
    end

    note_req_s = play_enable_i && load_new_note_i && (state_q == ACCEPT) &&
                 !advance_i && (duration_i != DUR_ZERO);

`ifdef VOICE_STEAL_EN
    min_idx_s = {IDX_W{1'b0}};
    min_val_s = cnt_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (cnt_q[i] < min_val_s) begin
        min_idx_s = i[IDX_W-1:0];
        min_val_s = cnt_q[i];
      end else begin
        min_val_s = min_val_s;
      end
    end
    tgt_s     = free_found_s ? free_idx_s : min_idx_s;
    do_load_s = note_req_s;
    steal_d   = note_req_s && !free_found_s;
    drop_d    = play_enable_i && load_new_note_i &&
                ((state_q == WAIT) || (!advance_i && (duration_i == DUR_ZERO)));
`else
    tgt_s     = free_idx_s;
    do_load_s = note_req_s && free_found_s;
    steal_d   = 1'b0;
    drop_d    = play_enable_i && load_new_note_i &&
                ((state_q == WAIT) || (!advance_i && (duration_i == DUR_ZERO)) ||
                 (note_req_s && !free_found_s));
`endif

    for (int i = 0; i < NUM_VOICES; i++) begin
      load_d[i] = do_load_s && (tgt_s == i[IDX_W-1:0]);
      if (!play_enable_i) begin
        cnt_d[i] = cnt_q[i];
      end else if (load_d[i]) begin
        cnt_d[i] = duration_i;
      end else if (beat_i && (cnt_q[i] != DUR_ZERO)) begin
        cnt_d[i] = cnt_q[i] - DUR_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      active_d[i] = (cnt_d[i] != DUR_ZERO);
    end
  end

  // Pacing FSM, voice counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ACCEPT;
      adv_q    <= DUR_ZERO;
      for (int i = 0; i < NUM_VOICES; i++) begin
        cnt_q[i] <= DUR_ZERO;
      end
      active_q <= {NUM_VOICES{1'b0}};
      load_q   <= {NUM_VOICES{1'b0}};
      note_q   <= {NOTE_W{1'b0}};
      dur_q    <= DUR_ZERO;
      done_q   <= 1'b1;
      steal_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      active_q <= active_d;
      load_q   <= load_d;
      steal_q  <= steal_d;
      drop_q   <= drop_d;
      if (do_load_s) begin
        note_q <= note_to_load_i;
        dur_q  <= duration_i;
      end else begin
        note_q <= note_q;
      end
      if (play_enable_i) begin
        case (state_q)
          ACCEPT: begin
            if (load_new_note_i && advance_i && (duration_i != DUR_ZERO)) begin
              adv_q   <= duration_i;
              state_q <= WAIT;
              done_q  <= 1'b0;
            end else begin
              state_q <= ACCEPT;
            end
          end
          WAIT: begin
            if (beat_i && (adv_q <= DUR_ONE)) begin
              adv_q   <= DUR_ZERO;
              state_q <= ACCEPT;
              done_q  <= 1'b1;
            end else if (beat_i) begin
              adv_q <= adv_q - DUR_ONE;
            end else begin
              adv_q <= adv_q;
            end
          end
          default: begin
            state_q <= ACCEPT;
            done_q  <= 1'b1;
          end
        endcase
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign voice_load_o     = load_q;
  assign voice_note_o     = note_q;
  assign voice_duration_o = dur_q;
  assign voice_active_o   = active_q;
  assign note_done_o      = done_q;
  assign steal_o          = steal_q;
  assign drop_o           = drop_q;

endmodule

// File: tb/tb_chord_voice_allocator.sv
// Directed scoreboard bench for chord_voice_allocator (NUM_VOICES=3, NOTE_W=6, DUR_W=6).
module tb_chord_voice_allocator;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_enable;
  logic       beat;
  logic       load_new_note;
  logic       advance;
  logic [5:0] note_to_load;
  logic [5:0] duration;
  logic [2:0] voice_load;
  logic [5:0] voice_note;
  logic [5:0] voice_duration;
  logic [2:0] voice_active;
  logic       note_done;
  logic       steal;
  logic       drop;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] load;
    logic [5:0] note;
    logic [5:0] dur;
    logic       stl;
    logic       drp;
  } exp_t;

  exp_t exp_q[$];

  chord_voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .play_enable_i    (play_enable),
    .beat_i           (beat),
    .load_new_note_i  (load_new_note),
    .advance_i        (advance),
    .note_to_load_i   (note_to_load),
    .duration_i       (duration),
    .voice_load_o     (voice_load),
    .voice_note_o     (voice_note),
    .voice_duration_o (voice_duration),
    .voice_active_o   (voice_active),
    .note_done_o      (note_done),
    .steal_o          (steal),
    .drop_o           (drop)
  );

  always #5 clk = ~clk;

  // Monitor: any load/steal/drop pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (voice_load != 3'b000 || steal || drop) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got load=%b note=%0d dur=%0d steal=%b drop=%b, expected no event",
                 voice_load, voice_note, voice_duration, steal, drop);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (voice_load != e.load || steal != e.stl || drop != e.drp ||
            (e.load != 3'b000 && (voice_note != e.note || voice_duration != e.dur))) begin
          failures++;
          $display("FAIL sb_event: got load=%b note=%0d dur=%0d steal=%b drop=%b, expected load=%b note=%0d dur=%0d steal=%b drop=%b",
                   voice_load, voice_note, voice_duration, steal, drop,
                   e.load, e.note, e.dur, e.stl, e.drp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_cnt(input logic [5:0] c0, input logic [5:0] c1, input logic [5:0] c2);
    chk("cnt0", {26'd0, dut.cnt_q[0]}, {26'd0, c0});
    chk("cnt1", {26'd0, dut.cnt_q[1]}, {26'd0, c1});
    chk("cnt2", {26'd0, dut.cnt_q[2]}, {26'd0, c2});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; returns just after the edge that sampled it.
  task automatic drive(input logic ld, input logic adv, input logic bt,
                       input logic [5:0] n, input logic [5:0] d);
    load_new_note = ld;
    advance       = adv;
    beat          = bt;
    note_to_load  = n;
    duration      = d;
    step();
    load_new_note = 1'b0;
    advance       = 1'b0;
    beat          = 1'b0;
  endtask

  task automatic push(input logic [2:0] l, input logic [5:0] n, input logic [5:0] d,
                      input logic s, input logic dr);
    exp_t e;
    e.load = l; e.note = n; e.dur = d; e.stl = s; e.drp = dr;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play_enable = 1'b1; beat = 1'b0; load_new_note = 1'b0;
    advance = 1'b0; note_to_load = 6'd0; duration = 6'd0;
    step(); step();
    reset = 1'b0;
    chk("rst_note_done", {31'd0, note_done}, 32'd1);
    chk("rst_active", {29'd0, voice_active}, 32'd0);

    // Three notes fill voices in index order.
    push(3'b001, 6'd10, 6'd4, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd10, 6'd4);
    push(3'b010, 6'd14, 6'd6, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd14, 6'd6);
    push(3'b100, 6'd17, 6'd8, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd17, 6'd8);
    chk("active_full", {29'd0, voice_active}, 32'd7);

    // Advance of 3 beats; a note arriving during WAIT is dropped.
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd3);
    chk("wait_done0", {31'd0, note_done}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    push(3'b000, 6'd0, 6'd0, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0, 6'd33, 6'd5);
    drive(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk("wait_done_b2", {31'd0, note_done}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk("wait_done_b3", {31'd0, note_done}, 32'd1);
    chk_cnt(6'd1, 6'd3, 6'd5);

    // Reset mid-WAIT with voices active.
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd2);
    chk("pre_rst_done", {31'd0, note_done}, 32'd0);
    do_reset();
    chk("mid_rst_done", {31'd0, note_done}, 32'd1);
    chk("mid_rst_active", {29'd0, voice_active}, 32'd0);
    chk("mid_rst_note", {26'd0, voice_note}, 32'd0);
    chk("mid_rst_dur", {26'd0, voice_duration}, 32'd0);
    chk_cnt(6'd0, 6'd0, 6'd0);

    // All voices busy (2,1,5) then note 20/d9.
    push(3'b001, 6'd30, 6'd2, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd30, 6'd2);
    push(3'b010, 6'd31, 6'd1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd31, 6'd1);
    push(3'b100, 6'd32, 6'd5, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd32, 6'd5);
`ifdef VOICE_STEAL_EN
    push(3'b010, 6'd20, 6'd9, 1'b1, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd20, 6'd9);
    chk_cnt(6'd2, 6'd9, 6'd5);
`else
    push(3'b000, 6'd0, 6'd0, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0, 6'd20, 6'd9);
    chk_cnt(6'd2, 6'd1, 6'd5);
    chk("nosteal_note_hold", {26'd0, voice_note}, 32'd32);
`endif

    // Load coinciding with beat: voice0 free, others 3/3.
    do_reset();
    push(3'b001, 6'd40, 6'd1, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd40, 6'd1);
    push(3'b010, 6'd41, 6'd4, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd41, 6'd4);
    push(3'b100, 6'd42, 6'd4, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b0, 6'd42, 6'd4);
    drive(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk("active_110", {29'd0, voice_active}, 32'd6);
    push(3'b001, 6'd50, 6'd9, 1'b0, 1'b0); drive(1'b1, 1'b0, 1'b1, 6'd50, 6'd9);
    chk_cnt(6'd9, 6'd2, 6'd2);

    // Frozen: beats and a load have no effect and produce no pulse.
    play_enable = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    drive(1'b1, 1'b0, 1'b0, 6'd60, 6'd5);
    chk_cnt(6'd9, 6'd2, 6'd2);
    chk("frozen_active", {29'd0, voice_active}, 32'd7);
    play_enable = 1'b1;
    step();

    // Zero-length advance is a no-op; zero-length note drops.
    drive(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
    chk("adv0_done", {31'd0, note_done}, 32'd1);
    push(3'b000, 6'd0, 6'd0, 1'b0, 1'b1); drive(1'b1, 1'b0, 1'b0, 6'd7, 6'd0);
    chk("note_hold", {26'd0, voice_note}, 32'd50);
    chk("dur_hold", {26'd0, voice_duration}, 32'd9);

    // Counters drain and saturate at zero.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b1, 6'd0, 6'd0);
    chk_cnt(6'd0, 6'd0, 6'd0);
    chk("drained_active", {29'd0, voice_active}, 32'd0);

    step(); step();
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
